// File: rtl/dcache_mshr_if.sv
// Bundles the LSQ request, memory bus, cache fill, CDB and halt signals of dcache_mshr.
// master = environment side (LSQ / memory model), slave = the MSHR itself.
interface dcache_mshr_if #(
  parameter int unsigned QDEPTH   = 16,
  parameter int unsigned IDX_BITS = 7,
  parameter int unsigned TAG_BITS = 22,
  parameter int unsigned PR_W     = 7,
  parameter int unsigned AR_W     = 5
);
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  logic                req_valid;
  logic                req_ready;
  logic                req_is_store;
  logic [63:0]         req_addr;
  logic [63:0]         req_data;
  logic [PR_W-1:0]     req_pr;
  logic [AR_W-1:0]     req_ar;

  logic [1:0]          mem_command;
  logic [63:0]         mem_addr;
  logic [63:0]         mem_data;
  logic [3:0]          mem_response;
  logic [3:0]          mem_tag;
  logic [63:0]         mem_rdata;

  logic                fill_en;
  logic [IDX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0] fill_tag;
  logic [63:0]         fill_data;

  logic                cdb_en;
  logic [PR_W-1:0]     cdb_pr;
  logic [AR_W-1:0]     cdb_ar;
  logic [63:0]         cdb_data;

  logic                halt_req;
  logic                halt_done;
  logic [CNT_W-1:0]    q_count;
  logic [3:0]          outstanding;
  logic                proto_err;

  modport master (
    output req_valid, req_is_store, req_addr, req_data, req_pr, req_ar,
    output mem_response, mem_tag, mem_rdata, halt_req,
    input  req_ready, mem_command, mem_addr, mem_data,
    input  fill_en, fill_idx, fill_tag, fill_data,
    input  cdb_en, cdb_pr, cdb_ar, cdb_data,
    input  halt_done, q_count, outstanding, proto_err
  );

  modport slave (
    input  req_valid, req_is_store, req_addr, req_data, req_pr, req_ar,
    input  mem_response, mem_tag, mem_rdata, halt_req,
    output req_ready, mem_command, mem_addr, mem_data,
    output fill_en, fill_idx, fill_tag, fill_data,
    output cdb_en, cdb_pr, cdb_ar, cdb_data,
    output halt_done, q_count, outstanding, proto_err
  );
endinterface

// File: rtl/dcache_mshr.sv
// Non-blocking data-cache miss controller: in-order request FIFO toward the tagged
// memory bus, tag table for outstanding loads, fill/CDB on return, and halt drain.
module dcache_mshr #(
  parameter int unsigned QDEPTH   = 16,
  parameter int unsigned NTAG     = 15,
  parameter int unsigned IDX_BITS = 7,
  parameter int unsigned TAG_BITS = 22,
  parameter int unsigned PR_W     = 7,
  parameter int unsigned AR_W     = 5
) (
  input  logic         clock,
  input  logic         reset,
  dcache_mshr_if.slave bus
);
  localparam int unsigned PTR_W   = $clog2(QDEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam logic [3:0]  TAG_MAX = 4'(NTAG);

  typedef struct packed {
    logic            is_store;
    logic [63:0]     addr;
    logic [63:0]     data;
    logic [PR_W-1:0] pr;
    logic [AR_W-1:0] ar;
  } req_t;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} halt_state_t;

  req_t                fifo [QDEPTH];
  logic [PTR_W-1:0]    head, tail;
  logic [CNT_W-1:0]    count;

  logic [15:0]         valid;
  logic [IDX_BITS-1:0] ent_idx [16];
  logic [TAG_BITS-1:0] ent_tag [16];
  logic [PR_W-1:0]     ent_pr  [16];
  logic [AR_W-1:0]     ent_ar  [16];

  req_t                head_ent;
  logic                empty, full, push, pop, alloc, ret_hit, collide;
  logic [IDX_BITS-1:0] head_idx;
  logic [TAG_BITS-1:0] head_tag;
  logic [3:0]          n_out;
  logic                proto_q;
  halt_state_t         state, state_next;
  logic                unused_addr_lsb;

  assign head_ent = fifo[head];
  assign empty    = count == '0;
  assign full     = count == CNT_W'(QDEPTH);
  assign push     = bus.req_valid & ~full;
  assign pop      = ~empty & (bus.mem_response != '0);
  assign alloc    = pop & ~head_ent.is_store & (bus.mem_response <= TAG_MAX);
  assign ret_hit  = (bus.mem_tag != '0) & valid[bus.mem_tag];
  // A tag freed by a return in the same cycle may be reallocated without error.
  assign collide  = pop & valid[bus.mem_response]
                  & ~(ret_hit & (bus.mem_tag == bus.mem_response));

  assign {head_tag, head_idx} = head_ent.addr[3+IDX_BITS+TAG_BITS-1:3];
  assign unused_addr_lsb      = ^head_ent.addr[2:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      proto_q <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (collide) proto_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push)
      fifo[tail] <= '{is_store: bus.req_is_store,
                      addr:     bus.req_addr,
                      data:     bus.req_is_store ? bus.req_data : '0,
                      pr:       bus.req_pr,
                      ar:       bus.req_ar};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
    end else begin
      if (ret_hit) valid[bus.mem_tag]      <= 1'b0;
      if (alloc)   valid[bus.mem_response] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (alloc) begin
      ent_idx[bus.mem_response] <= head_idx;
      ent_tag[bus.mem_response] <= head_tag;
      ent_pr[bus.mem_response]  <= head_ent.pr;
      ent_ar[bus.mem_response]  <= head_ent.ar;
    end
  end

  always_comb begin
    n_out = '0;
    for (int unsigned i = 0; i < 16; i++) n_out = n_out + 4'(valid[i]);
  end

  always_comb begin
    bus.mem_command = '0;
    bus.mem_addr    = '0;
    bus.mem_data    = '0;
    if (!empty) begin
      bus.mem_command = head_ent.is_store ? 2'd2 : 2'd1;
      bus.mem_addr    = {head_ent.addr[63:3], 3'b000};
      bus.mem_data    = head_ent.data;
    end
  end

  always_comb begin
    bus.fill_en   = 1'b0;
    bus.fill_idx  = '0;
    bus.fill_tag  = '0;
    bus.fill_data = '0;
    bus.cdb_en    = 1'b0;
    bus.cdb_pr    = '0;
    bus.cdb_ar    = '0;
    bus.cdb_data  = '0;
    if (ret_hit) begin
      bus.fill_en   = 1'b1;
      bus.fill_idx  = ent_idx[bus.mem_tag];
      bus.fill_tag  = ent_tag[bus.mem_tag];
      bus.fill_data = bus.mem_rdata;
      bus.cdb_en    = 1'b1;
      bus.cdb_pr    = ent_pr[bus.mem_tag];
      bus.cdb_ar    = ent_ar[bus.mem_tag];
      bus.cdb_data  = bus.mem_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (bus.halt_req) state_next = DRAIN;
      DRAIN:   if (empty && n_out == '0 && !push) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = RUN;
    endcase
  end

  assign bus.req_ready   = ~full;
  assign bus.q_count     = count;
  assign bus.outstanding = n_out;
  assign bus.proto_err   = proto_q;
  assign bus.halt_done   = state == DONE;
endmodule
